// File: rtl/input_memory_reader.sv
// ---------------------------------------------------------------------------
// input_memory_reader
//
// Streams one image of PIXEL_COUNT pixels out of a synchronous SRAM (one cycle
// read latency) into a 2-entry FIFO. The FIFO head is presented to the
// histogram datapath with a valid/ready handshake.
//
// Handshake: pixel_data is offered whenever pixel_valid=1. A transfer happens
// on every rising clock edge where pixel_valid=1 and pixel_ready=1. While
// pixel_valid=1 and pixel_ready=0, pixel_data holds its value. pixel_ready may
// be driven independently of pixel_valid.
//
// Ports
//   clock                      rising-edge system clock
//   reset                      asynchronous active-low reset
//   start_read                 level request to stream one image
//   mem_read_enable            SRAM read strobe
//   mem_address                SRAM read address (the read counter)
//   mem_read_data              SRAM data, valid the cycle after the strobe
//   pixel_data / pixel_valid   FIFO head toward the histogram datapath
//   pixel_ready                consumer accepts the head this cycle
//   input_memory_read_finished all pixels delivered (state DONE)
//   busy                       state is READ or DRAIN
// ---------------------------------------------------------------------------
module input_memory_reader #(
    parameter int ADDR_WIDTH  = 12,
    parameter int PIXEL_WIDTH = 8,
    parameter int PIXEL_COUNT = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start_read,
    output logic                   mem_read_enable,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    input  logic [PIXEL_WIDTH-1:0] mem_read_data,
    output logic [PIXEL_WIDTH-1:0] pixel_data,
    output logic                   pixel_valid,
    input  logic                   pixel_ready,
    output logic                   input_memory_read_finished,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXEL_COUNT - 1);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic                   inflight_q, inflight_d;
    logic [PIXEL_WIDTH-1:0] fifo_q [2];
    logic [PIXEL_WIDTH-1:0] fifo_d [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;
    logic                   finished_q, finished_d;
    logic                   busy_q, busy_d;

    logic                   pop;
    logic                   push;
    logic [2:0]             occupancy;
    logic                   read_en;

    always_comb begin
        pop       = (count_q != 2'd0) && pixel_ready;
        push      = inflight_q;
        // Buffered plus in-flight pixels, less the one leaving this cycle,
        // must leave room for the new read. Counting the same-cycle pop keeps
        // one read per cycle going while the consumer is ready.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q};
        read_en   = (state_q == READ) && ((occupancy - {2'b00, pop}) < 3'd2);

        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        inflight_d = read_en;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};

        // SRAM data for last cycle's strobe arrives now.
        if (push) begin
            fifo_d[wr_ptr_q] = mem_read_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            IDLE: begin
                if (start_read) begin
                    state_d  = READ;
                    rd_cnt_d = '0;
                end
            end
            READ: begin
                if (read_en) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // No reads issue in DRAIN, so an empty FIFO after this edge
                // means the last pixel has just left; finished rises next.
                if (count_d == 2'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!start_read) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        finished_d = (state_d == DONE);
        busy_d     = (state_d == READ) || (state_d == DRAIN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            finished_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            finished_q <= finished_d;
            busy_q     <= busy_d;
        end
    end

    // The strobe depends on this cycle's pop so that the SRAM is read every
    // cycle while the consumer keeps up; everything else is a register.
    assign mem_read_enable            = read_en;
    assign mem_address                = rd_cnt_q;
    assign pixel_valid                = (count_q != 2'd0);
    assign pixel_data                 = fifo_q[rd_ptr_q];
    assign input_memory_read_finished = finished_q;
    assign busy                       = busy_q;

endmodule

// File: tb/tb_input_memory_reader.sv
module tb_input_memory_reader;

    localparam int AW = 12;
    localparam int PW = 8;
    localparam int N  = 4096;

    logic          clock = 1'b0;
    logic          reset;
    logic          start_read, pixel_ready;
    logic          ren, pvalid, finished, busy;
    logic [AW-1:0] addr;
    logic [PW-1:0] rdata, pdata;

    logic          start_read1, pixel_ready1;
    logic          ren1, pvalid1, finished1, busy1;
    logic [AW-1:0] addr1;
    logic [PW-1:0] rdata1, pdata1;

    int errors = 0;
    int checks = 0;

    logic [PW-1:0] mem [N];
    logic [PW-1:0] exp_q [$];

    always #5 clock = ~clock;

    input_memory_reader #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW), .PIXEL_COUNT(N)) u_dut (
        .clock(clock), .reset(reset), .start_read(start_read),
        .mem_read_enable(ren), .mem_address(addr), .mem_read_data(rdata),
        .pixel_data(pdata), .pixel_valid(pvalid), .pixel_ready(pixel_ready),
        .input_memory_read_finished(finished), .busy(busy)
    );

    input_memory_reader #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW), .PIXEL_COUNT(1)) u_dut1 (
        .clock(clock), .reset(reset), .start_read(start_read1),
        .mem_read_enable(ren1), .mem_address(addr1), .mem_read_data(rdata1),
        .pixel_data(pdata1), .pixel_valid(pvalid1), .pixel_ready(pixel_ready1),
        .input_memory_read_finished(finished1), .busy(busy1)
    );

    // Synchronous SRAM model: one cycle read latency.
    always @(posedge clock) begin
        if (ren === 1'b1)  rdata  <= mem[addr];
        if (ren1 === 1'b1) rdata1 <= mem[addr1];
    end

    task automatic fill_random();
        for (int i = 0; i < N; i++) mem[i] = PW'($urandom_range(0, 255));
    endtask

    // Streams one image from the current mid-cycle point. The next rising
    // edge is the start edge. Modes: 0 always ready, 1 ready 1,0,0,1,
    // 2 ready low for 50 cycles, 3 random ready with start_read dropped early.
    task automatic run_image(input int mode, input int abort_at);
        int next_addr = 0;
        int outstanding = 0;
        int xfers = 0;
        int first_valid = 0;
        int last_xfer = 0;
        int limit = 4 * N + 200;
        bit done = 0;
        bit prev_stall = 0;
        logic [PW-1:0] prev_data = '0;
        logic [PW-1:0] e;
        logic pop;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
        start_read = 1'b1;
        for (int cyc = 1; cyc <= limit && !done; cyc++) begin
            @(posedge clock);
            #1;
            case (mode)
                0:       pixel_ready = 1'b1;
                1:       pixel_ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
                2:       pixel_ready = (cyc > 50);
                default: pixel_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 3 && cyc == 5) start_read = 1'b0;
            #1;
            pop = pvalid & pixel_ready;
            checks++;
            if (busy !== ~finished) begin
                errors++;
                $display("FAIL busy: cycle %0d busy=%b finished=%b", cyc, busy, finished);
            end
            if (ren === 1'b1) begin
                checks++;
                if (next_addr >= N || addr !== AW'(next_addr)) begin
                    errors++;
                    $display("FAIL read_addr: cycle %0d got %0d expected %0d", cyc, addr, next_addr);
                end
                checks++;
                if (outstanding - int'(pop) >= 2) begin
                    errors++;
                    $display("FAIL credit: cycle %0d read issued with %0d buffered/inflight, pop=%b", cyc, outstanding, pop);
                end
                next_addr++;
            end
            if (prev_stall) begin
                checks++;
                if (pvalid !== 1'b1 || pdata !== prev_data) begin
                    errors++;
                    $display("FAIL hold: cycle %0d valid=%b data=%0h expected valid=1 data=%0h", cyc, pvalid, pdata, prev_data);
                end
            end
            if (pvalid === 1'b1 && first_valid == 0) begin
                first_valid = cyc;
                if (mode == 0) begin
                    checks++;
                    if (cyc != 3) begin
                        errors++;
                        $display("FAIL latency: first valid in cycle %0d expected 3", cyc);
                    end
                end
            end
            if (pop === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pixel: extra pixel %0h after image end", pdata);
                end else begin
                    e = exp_q.pop_front();
                    if (pdata !== e) begin
                        errors++;
                        $display("FAIL pixel: index %0d got %0h expected %0h", xfers, pdata, e);
                    end
                end
                xfers++;
                last_xfer = cyc;
            end
            if (mode == 2 && cyc == 50) begin
                checks++;
                if (next_addr != 2 || pvalid !== 1'b1 || pdata !== mem[0]) begin
                    errors++;
                    $display("FAIL stall: reads=%0d valid=%b data=%0h expected 2,1,%0h", next_addr, pvalid, pdata, mem[0]);
                end
            end
            if (finished === 1'b1) begin
                done = 1;
                checks++;
                if (exp_q.size() != 0 || cyc != last_xfer + 1) begin
                    errors++;
                    $display("FAIL finish: cycle %0d remaining %0d last pixel cycle %0d", cyc, exp_q.size(), last_xfer);
                end
                if (mode == 0) begin
                    checks++;
                    if (last_xfer - first_valid + 1 != N) begin
                        errors++;
                        $display("FAIL throughput: %0d cycles for %0d pixels", last_xfer - first_valid + 1, N);
                    end
                end
            end
            prev_stall  = pvalid & ~pixel_ready;
            prev_data   = pdata;
            outstanding = outstanding + int'(ren) - int'(pop);
            if (abort_at > 0 && xfers == abort_at) return;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout: finished not seen, %0d pixels delivered", xfers);
        end
    endtask

    task automatic drop_start();
        start_read = 1'b0;
        @(posedge clock);
        #2;
        checks++;
        if (finished !== 1'b0 || busy !== 1'b0 || ren !== 1'b0) begin
            errors++;
            $display("FAIL drop: finished=%b busy=%b ren=%b expected 0,0,0", finished, busy, ren);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start_read = 1'b0;  pixel_ready = 1'b0;
        start_read1 = 1'b0; pixel_ready1 = 1'b0;
        #8;
        checks++;
        if ({ren, addr, pvalid, pdata, finished, busy} !== '0) begin
            errors++;
            $display("FAIL reset_out: got %b expected 0", {ren, addr, pvalid, pdata, finished, busy});
        end
        checks++;
        if ({ren1, addr1, pvalid1, pdata1, finished1, busy1} !== '0) begin
            errors++;
            $display("FAIL reset_out1: got %b expected 0", {ren1, addr1, pvalid1, pdata1, finished1, busy1});
        end
        #2 reset = 1'b1;
        @(posedge clock);
        #2;
    endtask

    task automatic test_full();
        for (int i = 0; i < N; i++) mem[i] = PW'(i);
        run_image(0, 0);
    endtask

    // start_read held high after finishing: no retrigger, no reads.
    task automatic test_hold();
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #2;
            checks++;
            if (finished !== 1'b1 || ren !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL hold_done: finished=%b ren=%b busy=%b expected 1,0,0", finished, ren, busy);
            end
        end
        drop_start();
    endtask

    task automatic test_toggle();
        fill_random();
        run_image(1, 0);
        drop_start();
    endtask

    task automatic test_stall();
        fill_random();
        run_image(2, 0);
        drop_start();
    endtask

    task automatic test_random_ready();
        fill_random();
        run_image(3, 0);
        @(posedge clock);
        #2;
        checks++;
        if (finished !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL random_idle: finished=%b busy=%b expected 0,0", finished, busy);
        end
    endtask

    task automatic test_reset_mid();
        fill_random();
        run_image(0, 100);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({ren, addr, pvalid, pdata, finished, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got %b expected 0", {ren, addr, pvalid, pdata, finished, busy});
        end
        @(posedge clock);
        #2 reset = 1'b1;
        run_image(0, 0);
        drop_start();
    endtask

    task automatic test_single();
        int reads = 0;
        int pix = 0;
        int fin_cyc = 0;
        fill_random();
        pixel_ready1 = 1'b1;
        start_read1 = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clock);
            #2;
            if (ren1 === 1'b1) begin
                checks++;
                if (addr1 !== '0 || reads != 0 || cyc != 1) begin
                    errors++;
                    $display("FAIL single_read: cycle %0d addr %0d read #%0d", cyc, addr1, reads);
                end
                reads++;
            end
            if (pvalid1 === 1'b1) begin
                checks++;
                if (pdata1 !== mem[0] || cyc != 3) begin
                    errors++;
                    $display("FAIL single_pixel: cycle %0d got %0h expected %0h in cycle 3", cyc, pdata1, mem[0]);
                end
                pix++;
            end
            if (finished1 === 1'b1 && fin_cyc == 0) fin_cyc = cyc;
        end
        checks++;
        if (reads != 1 || pix != 1 || fin_cyc != 4 || finished1 !== 1'b1) begin
            errors++;
            $display("FAIL single: reads=%0d pixels=%0d finished cycle %0d expected 1,1,4", reads, pix, fin_cyc);
        end
        start_read1 = 1'b0;
        @(posedge clock);
        #2;
    endtask

    initial begin
        test_reset();
        test_full();
        test_hold();
        test_toggle();
        test_stall();
        test_random_ready();
        test_reset_mid();
        test_single();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
